// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if: instruction-memory req/ack bus, branch redirect and IF/ID valid/ready
// handshake seen by the fetch controller.
interface inst_fetch_ctrl_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output mem_req, mem_addr, if_valid, if_instr, if_pc,
        input  mem_ack, mem_rdata, branch_taken, branch_addr, if_ready
    );

    modport slave (
        input  mem_req, mem_addr, if_valid, if_instr, if_pc,
        output mem_ack, mem_rdata, branch_taken, branch_addr, if_ready
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: owns the fetch PC, requests words from instruction memory, buffers them in a
// prefetch FIFO for IF/ID and flushes on taken branches (dropping a fetch that is still in flight).
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_ctrl_if.master  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {RUN, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [31:0]   npc_q   [DEPTH];
    logic [31:0]   npc_d   [DEPTH];
    logic          ack, pend, push, pop, br;

    always_comb begin
        br         = bus.branch_taken;
        ack        = req_q & bus.mem_ack;
        pend       = req_q & ~ack;
        push       = ack & (state_q == RUN) & ~br;
        pop        = (count_q != '0) & bus.if_ready & ~br;
        instr_d    = instr_q;
        npc_d      = npc_q;
        if (push) begin
            instr_d[wr_q] = bus.mem_rdata;
            npc_d[wr_q]   = fetch_pc_q + 32'd4;
        end
        rd_d       = br ? '0 : rd_q + AW'(pop);
        wr_d       = br ? '0 : wr_q + AW'(push);
        count_d    = br ? '0 : count_q + CW'(push) - CW'(pop);
        fetch_pc_d = br ? {bus.branch_addr[31:2], 2'b00} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        // an open request keeps its address; a drained DROP ack returns to RUN
        state_d    = br ? (pend ? DROP : RUN) : (ack ? RUN : state_q);
        req_d      = pend | (count_d < CW'(DEPTH));
        addr_d     = pend ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        npc_q   <= npc_d;
    end

    assign bus.mem_req  = req_q;
    assign bus.mem_addr = addr_q;
    assign bus.if_valid = (count_q != '0);
    assign bus.if_instr = bus.if_valid ? instr_q[rd_q] : '0;
    assign bus.if_pc    = bus.if_valid ? npc_q[rd_q] : '0;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: randomized memory wait states, branches and IF/ID back-pressure checked
// cycle by cycle against a queue-based fetch model.
module tb_inst_fetch_ctrl;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'd0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_ctrl_if bus();

    inst_fetch_ctrl #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // model: queue of fetch addresses waiting for IF/ID, plus fetch/request bookkeeping
    logic [31:0] m_q[$];
    logic [31:0] m_pc, m_addr;
    bit          m_req, m_drop;

    int maxw = 0, p_ready = 100, p_br = 0;
    bit busy = 0;
    int wcnt = 0;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return {a[15:0] ^ 16'hbeef, a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = RST_PC;
        m_addr = RST_PC;
        m_req  = 0;
        m_drop = 0;
        busy   = 0;
        wcnt   = 0;
    endtask

    task automatic model_step(bit ack_in, bit br, logic [31:0] ba, bit rdy);
        bit ack, pend, pop;
        ack  = ack_in && m_req;
        pend = m_req && !ack;
        pop  = (m_q.size() != 0) && rdy;
        if (br) begin
            m_q.delete();
            m_pc   = ba;
            m_drop = pend;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (ack) begin
                if (m_drop) m_drop = 0;
                else begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_req  = pend || (m_q.size() < DEPTH);
        m_addr = pend ? m_addr : m_pc;
    endtask

    task automatic check_outputs();
        bit v;
        v = (m_q.size() != 0);
        check("mem_req", {31'd0, bus.mem_req}, {31'd0, m_req});
        check("mem_addr", bus.mem_addr, m_addr);
        check("if_valid", {31'd0, bus.if_valid}, {31'd0, v});
        check("if_pc", bus.if_pc, v ? m_q[0] + 32'd4 : 32'd0);
        check("if_instr", bus.if_instr, v ? word_of(m_q[0]) : 32'd0);
    endtask

    task automatic drive_idle();
        bus.mem_ack      = 0;
        bus.mem_rdata    = 0;
        bus.branch_taken = 0;
        bus.branch_addr  = 0;
        bus.if_ready     = 0;
    endtask

    task automatic cycle();
        logic [31:0] r;
        @(negedge clk);
        check_outputs();
        bus.mem_ack = 0;
        if (bus.mem_req) begin
            if (!busy) begin
                busy = 1;
                wcnt = $urandom_range(0, maxw);
            end
            if (wcnt == 0) begin
                bus.mem_ack = 1;
                busy = 0;
            end else wcnt--;
        end
        r = $urandom();
        bus.mem_rdata    = bus.mem_ack ? word_of(bus.mem_addr) : r;
        bus.if_ready     = ($urandom_range(0, 99) < p_ready);
        bus.branch_taken = ($urandom_range(0, 99) < p_br);
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       bus.branch_addr = 32'hFFFF_FFF8;
            1:       bus.branch_addr = {24'd0, r[7:2], 2'b00};
            default: bus.branch_addr = {r[31:2], 2'b00};
        endcase
        @(posedge clk);
        model_step(bus.mem_ack, bus.branch_taken, bus.branch_addr, bus.if_ready);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        drive_idle();
        model_reset();
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, RST_PC);
        check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_if_instr", bus.if_instr, 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        drive_idle();
        model_reset();
        do_reset();
        maxw = 0; p_ready = 100; p_br = 0;
        run(30);
        p_ready = 0;
        run(6);
        p_ready = 100;
        run(10);
        maxw = 3;
        run(30);
        p_br = 8; p_ready = 70;
        run(300);
        @(negedge clk);
        do_reset();
        run(300);
        maxw = 2; p_ready = 50; p_br = 15;
        run(400);
        maxw = 0; p_ready = 90; p_br = 5;
        run(200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch controller sitting between the ARM pipeline's IF stage and the instruction memory. Owns the fetch PC, issues word requests to the instruction memory through a req/ack handshake tolerating any number of wait states, buffers returned words in a small prefetch FIFO, and presents them to IF/ID with a valid/ready handshake. Handles taken branches by flushing the FIFO and discarding any in-flight fetch.

## Interface
- RESET_PC, 32'd0, fetch address after reset
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  byte address of requested word, always 4-aligned
- mem_ack  in  1  memory returns mem_rdata this cycle; may be high in the same cycle mem_req rises
- mem_rdata  in  32  instruction word, valid when mem_ack
- branch_taken  in  1  one-cycle pulse from EXE: redirect fetch
- branch_addr  in  32  redirect target, valid with branch_taken
- if_valid  out  1  if_instr/if_pc hold a valid entry
- if_instr  out  32  FIFO head instruction
- if_pc  out  32  FIFO head fetch address + 4
- if_ready  in  1  IF/ID accepts head this cycle (pop when if_valid & if_ready)

## Operation
- Registers: fetch_pc, req flag, FIFO (DEPTH entries of {instr, pc+4}, rd/wr pointers, count), state ∈ {RUN, DROP}.
- mem_req = req flag; mem_addr = fetch_pc. Once mem_req is high, mem_req and mem_addr hold stable until the cycle mem_ack is seen.
- RUN, ack: push {mem_rdata, fetch_pc+4}; fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC → 0x00000000).
- Request (re)issue at each edge: req flag next = (count_next < DEPTH), where count_next includes this cycle's push and pop; an unacked request always stays high.
- Push never overflows: a request is only open when a slot exists and only pops occur meanwhile.
- Branch (priority over push and pop): FIFO emptied (count=0, pointers reset), fetch_pc ← branch_addr; any same-cycle pop or ack data discarded.
  - branch with mem_req high and no mem_ack: state → DROP.
  - branch with mem_ack, or mem_req low: stay RUN; req flag set next cycle.
- DROP: mem_req stays high at the old address; on mem_ack the data is discarded, fetch_pc unchanged, state → RUN, req flag stays set (new address presented next cycle). Another branch in DROP overwrites fetch_pc, stays DROP; branch coincident with DROP's ack: data discarded, fetch_pc ← new target, → RUN.
- if_valid = (count ≠ 0); if_instr/if_pc driven from head entry; show 0 when empty.

## Timing
- Reset (async assert, sync release): fetch_pc=RESET_PC, req=0, state=RUN, count=0, mem_req=0, mem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
- First mem_req on the first rising edge after rst deasserts.
- Ack in cycle t → if_valid earliest in cycle t+1.
- Zero-wait memory (ack same cycle as req) with if_ready held high: one instruction per cycle sustained, mem_addr increments by 4 every cycle.
- if_ready low: FIFO fills to DEPTH, mem_req falls the cycle after the filling ack; first pop re-raises mem_req next cycle.
- Branch in cycle t: if_valid=0 in t+1; mem_addr=branch_addr with mem_req high in t+1 (RUN case) or in cycle after the drop ack (DROP case).
- Reset mid-transaction: all state cleared immediately; pending ack ignored.

## Test plan
- Reset release, zero-wait memory, if_ready=1 → mem_addr 0,4,8,… on consecutive cycles; if_instr follows with one-cycle lag, if_pc 4,8,12,….
- if_ready=0 for 6 cycles, DEPTH=2 → exactly 2 entries (pc+4 = 4, 8), mem_req low from third cycle; release if_ready → entries popped in order, fetch resumes at 0x8.
- Memory 3 wait states → mem_addr stable across 4 cycles of mem_req, one push per ack, no duplicates or skips.
- Branch to 0x40 while request to 0x10 pending (3 wait states) → DROP; ack data for 0x10 discarded, next mem_addr=0x40, first if_pc=0x44.
- Branch to 0x80 same cycle as ack and pop with FIFO holding 2 → FIFO empty next cycle, acked word dropped, mem_addr=0x80.
- Two branches (0x40 then 0x100) during one DROP → single discard, next fetch at 0x100; fetch_pc 0xFFFFFFFC wraps to 0x0.
